// File: rtl/vga.sv
// 640x480@60 VGA timing generator with a colour-bar test pattern and white border.
// Sync and colour outputs are registered together, one clock behind the counters.
module vga (
    input  logic clk,
    input  logic rst,
    output logic r,
    output logic g,
    output logic b,
    output logic hsync,
    output logic vsync
);

    localparam int unsigned CW = 10;

    localparam logic [CW-1:0] H_LAST       = 10'd799;
    localparam logic [CW-1:0] H_ACTIVE     = 10'd640;
    localparam logic [CW-1:0] H_RIGHT      = 10'd639;
    localparam logic [CW-1:0] H_SYNC_FIRST = 10'd656;
    localparam logic [CW-1:0] H_SYNC_LAST  = 10'd751;
    localparam logic [CW-1:0] V_LAST       = 10'd524;
    localparam logic [CW-1:0] V_ACTIVE     = 10'd480;
    localparam logic [CW-1:0] V_BOTTOM     = 10'd479;
    localparam logic [CW-1:0] V_HALF       = 10'd240;
    localparam logic [CW-1:0] V_SYNC_FIRST = 10'd490;
    localparam logic [CW-1:0] V_SYNC_LAST  = 10'd491;
    localparam logic [CW-1:0] BAR_WIDTH    = 10'd80;

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [2:0]    rgb_q, rgb_d;
    logic [2:0]    bar_k;
    logic          active;
    logic          border;

    // Counter advance, sync decode and pattern for the pixel currently addressed
    always_comb begin
        hc_d    = hc_q + 10'd1;
        vc_d    = vc_q;
        hsync_d = 1'b1;
        vsync_d = 1'b1;
        rgb_d   = 3'b000;
        bar_k   = 3'(hc_q / BAR_WIDTH);
        active  = (hc_q < H_ACTIVE) && (vc_q < V_ACTIVE);
        border  = (hc_q == '0) || (hc_q == H_RIGHT) || (vc_q == '0) || (vc_q == V_BOTTOM);

        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end

        if ((hc_q >= H_SYNC_FIRST) && (hc_q <= H_SYNC_LAST)) begin
            hsync_d = 1'b0;
        end
        if ((vc_q >= V_SYNC_FIRST) && (vc_q <= V_SYNC_LAST)) begin
            vsync_d = 1'b0;
        end

        // Top half shows the bar index, bottom half its complement
        if (active) begin
            if (border) begin
                rgb_d = 3'b111;
            end else if (vc_q < V_HALF) begin
                rgb_d = bar_k;
            end else begin
                rgb_d = ~bar_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 3'b000;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign r     = rgb_q[2];
    assign g     = rgb_q[1];
    assign b     = rgb_q[0];
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vga.sv
// Scoreboard bench for vga: driver queues the expected {hsync,vsync,r,g,b} per edge,
// a negedge monitor pops and compares, and also measures sync pulse widths and periods.
module tb_vga;

    logic clk;
    logic rst;
    logic r, g, b, hsync, vsync;

    vga dut (
        .clk   (clk),
        .rst   (rst),
        .r     (r),
        .g     (g),
        .b     (b),
        .hsync (hsync),
        .vsync (vsync)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic [4:0] exp;
        logic       rst_edge;
        logic       directed;
        int         idx;
    } entry_t;

    entry_t     sb_q[$];
    logic [4:0] dir_tab [int];
    int         n_total = 0;
    int         n_pass  = 0;
    int         idx     = 0;
    logic       done    = 1'b0;

    // Sync measurement state
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int   hlow    = 0;
    int   vlow    = 0;
    int   hcyc    = 0;
    logic hseen   = 1'b0;
    int   hfalls  = 0;

    task automatic check(input string name, input int a, input int e, input int at);
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL %s at pixel %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, at, a, a, e, e);
    endtask

    function automatic logic [4:0] pix(input int i);
        int h, v;
        logic hs, vs;
        logic [2:0] k, c;
        h  = i % 800;
        v  = (i / 800) % 525;
        hs = !(h >= 656 && h <= 751);
        vs = !(v >= 490 && v <= 491);
        k  = 3'(h / 80);
        c  = 3'b000;
        if (h < 640 && v < 480) begin
            if (h == 0 || h == 639 || v == 0 || v == 479) c = 3'b111;
            else if (v < 240) c = k;
            else c = ~k;
        end
        return {hs, vs, c};
    endfunction

    function automatic int pidx(input int h, input int v);
        return v * 800 + h;
    endfunction

    // Hand-computed expectations, {hsync,vsync,r,g,b}
    initial begin
        dir_tab[pidx(0,   0)]   = 5'b11111;
        dir_tab[pidx(85,  100)] = 5'b11001;
        dir_tab[pidx(565, 100)] = 5'b11111;
        dir_tab[pidx(85,  300)] = 5'b11110;
        dir_tab[pidx(700, 100)] = 5'b01000;
        dir_tab[pidx(700, 300)] = 5'b01000;
        dir_tab[pidx(655, 0)]   = 5'b11000;
        dir_tab[pidx(656, 0)]   = 5'b01000;
        dir_tab[pidx(751, 0)]   = 5'b01000;
        dir_tab[pidx(752, 0)]   = 5'b11000;
        dir_tab[pidx(639, 200)] = 5'b11111;
        dir_tab[pidx(638, 300)] = 5'b11000;
        dir_tab[pidx(100, 479)] = 5'b11111;
        dir_tab[pidx(100, 480)] = 5'b11000;
        dir_tab[pidx(0,   489)] = 5'b11000;
        dir_tab[pidx(0,   490)] = 5'b10000;
        dir_tab[pidx(0,   491)] = 5'b10000;
        dir_tab[pidx(0,   492)] = 5'b11000;
        dir_tab[pidx(656, 490)] = 5'b00000;
        dir_tab[pidx(160, 239)] = 5'b11010;
        dir_tab[pidx(160, 240)] = 5'b11101;
        dir_tab[pidx(1,   1)]   = 5'b11000;
    end

    task automatic step(input logic rv);
        entry_t e;
        @(negedge clk);
        rst = rv;
        @(posedge clk);
        e.rst_edge = rv;
        e.directed = 1'b0;
        if (rv) begin
            e.exp = 5'b11000;
            e.idx = -1;
            idx   = 0;
        end else begin
            e.idx = idx;
            if (dir_tab.exists(idx)) begin
                e.exp      = dir_tab[idx];
                e.directed = 1'b1;
            end else begin
                e.exp = pix(idx);
            end
            idx++;
        end
        sb_q.push_back(e);
    endtask

    // Driver: reset, run to pixel (400,300), reset there, then one full frame and a bit
    initial begin
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        while (idx < pidx(400, 300)) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 420500; i++) step(1'b0);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
    end

    // Monitor: pop one expectation per edge and compare
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            entry_t e;
            logic [4:0] act;
            e   = sb_q.pop_front();
            act = {hsync, vsync, r, g, b};
            if (e.rst_edge)       check("reset_out", int'(act), int'(e.exp), e.idx);
            else if (e.directed)  check("directed", int'(act), int'(e.exp), e.idx);
            else                  check("pixel", int'(act), int'(e.exp), e.idx);

            if (e.rst_edge) begin
                prev_hs = 1'b1;
                prev_vs = 1'b1;
                hlow    = 0;
                vlow    = 0;
                hcyc    = 0;
                hseen   = 1'b0;
                hfalls  = 0;
            end else begin
                hcyc++;
                if (prev_hs && !hsync) begin
                    if (hseen) check("hsync_period", hcyc, 800, e.idx);
                    check("hsync_fall_hc", e.idx % 800, 656, e.idx);
                    hseen = 1'b1;
                    hcyc  = 0;
                    hfalls++;
                end
                if (!hsync) hlow++;
                if (!prev_hs && hsync) begin
                    check("hsync_low_len", hlow, 96, e.idx);
                    hlow = 0;
                end
                if (prev_vs && !vsync) check("vsync_fall_px", e.idx, pidx(0, 490), e.idx);
                if (!vsync) vlow++;
                if (!prev_vs && vsync) begin
                    check("vsync_low_len", vlow, 1600, e.idx);
                    vlow = 0;
                end
                if (!hsync || !vsync) check("rgb_in_sync", int'({r, g, b}), 0, e.idx);
                prev_hs = hsync;
                prev_vs = vsync;
            end
        end
    end

    initial begin
        wait (done);
        check("lines_per_frame", hfalls, 525, idx);
        check("scoreboard_drained", sb_q.size(), 0, idx);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga.md
VGA -- requirements
Module: vga

Interface
REQ-001 clk  input  1  pixel clock, 25 MHz nominal (40 ns period); all state changes on the rising edge.
REQ-002 rst  input  1  reset; synchronous and active-high.
REQ-003 r  output  1  red pixel bit; registered.
REQ-004 g  output  1  green pixel bit; registered.
REQ-005 b  output  1  blue pixel bit; registered.
REQ-006 hsync  output  1  horizontal sync; active-low; registered.
REQ-007 vsync  output  1  vertical sync; active-low; registered.
REQ-008 The block SHALL have no parameters and no ports other than those listed.

Function
REQ-009 The block SHALL hold an unsigned 10-bit horizontal counter hc covering 0..799 and an unsigned 10-bit vertical counter vc covering 0..524.
REQ-010 hc SHALL increment each clock; at 799 it SHALL wrap to 0 and vc SHALL increment on the same edge.
REQ-011 vc SHALL wrap from 524 to 0 on the edge where hc wraps; frame = 800 x 525 = 420000 clocks.
REQ-012 Horizontal zones: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-013 Vertical zones: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-014 hsync SHALL be 0 when hc is in 656..751 and 1 otherwise; vsync SHALL be 0 when vc is in 490..491 and 1 otherwise; vsync is independent of hc.
REQ-015 Active video = hc<640 AND vc<480; outside active video r=g=b=0.
REQ-016 Inside active video, border pixels (hc=0, hc=639, vc=0 or vc=479) SHALL be white (r=g=b=1).
REQ-017 Other active pixels: bar index k = hc/80 (0..7); rows vc<240 SHALL output {r,g,b}=k; rows vc>=240 SHALL output {r,g,b}=~k (bitwise).
REQ-018 All five outputs SHALL be registered from the current (hc,vc) on the same edge the counters advance; outputs lag the counters by exactly one clock.
REQ-019 Sync and colour outputs SHALL be mutually aligned with the same one-clock latency; no combinational path from inputs to outputs.

Reset
REQ-020 While rst=1 on a rising edge: hc<=0, vc<=0, hsync<=1, vsync<=1, r=g=b<=0.
REQ-021 On the k-th rising edge with rst=0 after reset (k>=1), the outputs SHALL reflect the pixel at linear index k-1 (hc=(k-1) mod 800, vc=((k-1) div 800) mod 525).
REQ-022 Reset asserted mid-frame SHALL take effect on the next edge and restart timing from (0,0) exactly as in REQ-020/021; no partial-frame state survives.
REQ-023 Before the first reset, output values are unspecified; the bench SHALL NOT check them.

Verification
REQ-024 Reset then 1 clock -> output shows pixel (0,0): hsync=1, vsync=1, r=g=b=1 (border).
REQ-025 Run one line -> hsync falls on the edge reflecting hc=656, stays 0 for exactly 96 clocks, rises at hc=752; hsync period 800 clocks (32.0 us at 25 MHz).
REQ-026 Run 2 frames -> vsync low for exactly 1600 consecutive clocks per frame, starting at pixel (0,490); vsync falling edges exactly 420000 clocks (16.8 ms) apart.
REQ-027 Sample line vc=100 -> hc=85 gives rgb=001, hc=565 gives rgb=111; line vc=300, hc=85 gives rgb=110; hc=700 any line gives rgb=000.
REQ-028 Assert rst for one clock at pixel (400,300) -> next outputs hsync=1, vsync=1, rgb=000; following edge shows pixel (0,0) again with rgb=111.
REQ-029 Over 1000000 clocks -> rgb never nonzero while hsync=0 or vsync=0; line count per frame = 525.
